// File: rtl/reg_ctx_sequencer.sv
// Context save/restore sequencer: borrows the LC-3 register file SR1 and write ports to stream R0..R(NUM_REGS-1) to/from memory.
// Defining REG_CTX_CHECKSUM_EN adds a running modulo-2^DATA_W sum of the transferred words on Checksum.
module reg_ctx_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start_Save,
    input  logic              Start_Restore,
    input  logic [ADDR_W-1:0] Base_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Checksum,
    input  logic [2:0]        CPU_SR1,
    input  logic [2:0]        CPU_DR,
    input  logic              CPU_LD_REG,
    input  logic [DATA_W-1:0] CPU_BUS,
    output logic [2:0]        RF_SR1,
    output logic [2:0]        RF_DR,
    output logic              RF_LD_REG,
    output logic [DATA_W-1:0] RF_BUS,
    input  logic [DATA_W-1:0] RF_SR1OUT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_READY
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE_RD,
        S_RESTORE_WR,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        idx;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] hold;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              start;

    // Address wraps naturally at 2^ADDR_W through the truncating add.
    assign addr  = base + ADDR_W'(idx);
    assign last  = (idx == LAST_IDX);
    assign start = Start_Save || Start_Restore;

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b1;
        Done      = 1'b0;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        RF_SR1    = CPU_SR1;
        RF_DR     = CPU_DR;
        RF_BUS    = CPU_BUS;
        RF_LD_REG = 1'b0;
        case (state)
            S_IDLE: begin
                Busy      = 1'b0;
                RF_LD_REG = CPU_LD_REG;
                if (Start_Save)         state_nxt = S_SAVE;
                else if (Start_Restore) state_nxt = S_RESTORE_RD;
            end
            S_SAVE: begin
                RF_SR1    = idx;
                MEM_WE    = 1'b1;
                MEM_ADDR  = addr;
                MEM_WDATA = RF_SR1OUT;
                if (MEM_READY && last) state_nxt = S_DONE;
            end
            S_RESTORE_RD: begin
                MEM_RE   = 1'b1;
                MEM_ADDR = addr;
                if (MEM_READY) state_nxt = S_RESTORE_WR;
            end
            S_RESTORE_WR: begin
                RF_DR     = idx;
                RF_BUS    = hold;
                RF_LD_REG = 1'b1;
                state_nxt = last ? S_DONE : S_RESTORE_RD;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx <= '0;
        end else begin
            case (state)
                S_IDLE:       if (start) idx <= '0;
                S_SAVE:       if (MEM_READY && !last) idx <= idx + 3'd1;
                S_RESTORE_WR: if (!last) idx <= idx + 3'd1;
                default:      ;
            endcase
        end
    end

    // Base and read-hold are pure data; outputs that expose them are gated by state.
    always_ff @(posedge Clk) begin
        if (state == S_IDLE && start)          base <= Base_Addr;
        if (state == S_RESTORE_RD && MEM_READY) hold <= MEM_RDATA;
    end

`ifdef REG_CTX_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge Clk) begin
        if (Reset)                              csum <= '0;
        else if (state == S_IDLE && start)      csum <= '0;
        else if (state == S_SAVE && MEM_READY)  csum <= csum + RF_SR1OUT;
        else if (state == S_RESTORE_RD && MEM_READY) csum <= csum + MEM_RDATA;
    end

    assign Checksum = csum;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Self-checking bench for reg_ctx_sequencer: register file and memory models, directed cases plus randomized transfers.
module tb_reg_ctx_sequencer;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 16;

`ifdef REG_CTX_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start_Save;
    logic          Start_Restore;
    logic [AW-1:0] Base_Addr;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] Checksum;
    logic [2:0]    CPU_SR1;
    logic [2:0]    CPU_DR;
    logic          CPU_LD_REG;
    logic [DW-1:0] CPU_BUS;
    logic [2:0]    RF_SR1;
    logic [2:0]    RF_DR;
    logic          RF_LD_REG;
    logic [DW-1:0] RF_BUS;
    logic [DW-1:0] RF_SR1OUT;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_WE;
    logic          MEM_RE;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_READY;

    always #5 Clk = ~Clk;

    reg_ctx_sequencer #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .Start_Save(Start_Save), .Start_Restore(Start_Restore), .Base_Addr(Base_Addr),
        .Busy(Busy), .Done(Done), .Checksum(Checksum),
        .CPU_SR1(CPU_SR1), .CPU_DR(CPU_DR), .CPU_LD_REG(CPU_LD_REG), .CPU_BUS(CPU_BUS),
        .RF_SR1(RF_SR1), .RF_DR(RF_DR), .RF_LD_REG(RF_LD_REG), .RF_BUS(RF_BUS),
        .RF_SR1OUT(RF_SR1OUT),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
        .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY)
    );

    // Environment: register file, memory with programmable ready latency, bus monitor.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] rf  [0:7];
    logic [DW-1:0] mem [0:65535];
    wr_t           wr_q[$];
    int            lat = 0;
    int            wait_cnt = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            ld_busy_cnt = 0;
    int            re_cnt = 0;
    int            ov_err = 0;
    int            pulse_err = 0;
    int            stab_err = 0;
    logic          prev_ld = 1'b0;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    assign RF_SR1OUT = rf[RF_SR1];
    assign MEM_RDATA = mem[MEM_ADDR];
    assign MEM_READY = (lat == 0) ? 1'b1 : ((MEM_WE || MEM_RE) && (wait_cnt >= lat));

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (RF_LD_REG) rf[RF_DR] <= RF_BUS;
        if (MEM_WE && MEM_READY) wr_q.push_back({MEM_ADDR, MEM_WDATA});
        if (Reset || !(MEM_WE || MEM_RE) || MEM_READY) wait_cnt <= 0;
        else                                            wait_cnt <= wait_cnt + 1;
        if (Done) done_cnt <= done_cnt + 1;
        if (Busy && RF_LD_REG) ld_busy_cnt <= ld_busy_cnt + 1;
        if (MEM_RE) re_cnt <= re_cnt + 1;
        if (MEM_WE && MEM_RE) ov_err <= ov_err + 1;
        if (Busy && RF_LD_REG && prev_ld) pulse_err <= pulse_err + 1;
        if (prev_wait && (MEM_WE || MEM_RE) && MEM_ADDR != prev_addr) stab_err <= stab_err + 1;
        prev_ld   <= Busy && RF_LD_REG;
        prev_wait <= (MEM_WE || MEM_RE) && !MEM_READY && !Reset;
        prev_addr <= MEM_ADDR;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input bit sv, input bit rs, input logic [AW-1:0] base, output int s);
        @(negedge Clk);
        Start_Save    = sv;
        Start_Restore = rs;
        Base_Addr     = base;
        s             = cyc;
        @(negedge Clk);
        Start_Save    = 1'b0;
        Start_Restore = 1'b0;
        Base_Addr     = 16'($urandom);
    endtask

    task automatic wait_done(input bit noise, output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (Done) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
            if (noise) begin
                CPU_LD_REG    = 1'($urandom);
                CPU_DR        = 3'($urandom);
                CPU_SR1       = 3'($urandom);
                CPU_BUS       = 16'($urandom);
                Start_Save    = ($urandom_range(0, 3) == 0);
                Start_Restore = ($urandom_range(0, 3) == 0);
            end
            @(negedge Clk);
        end
        CPU_LD_REG    = 1'b0;
        Start_Save    = 1'b0;
        Start_Restore = 1'b0;
        if (!ok) check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_save(input logic [AW-1:0] base, input int L, input bit noise,
                            input bit both, input bit cpu_wr);
        logic [DW-1:0] snap [0:7];
        logic [DW-1:0] sum;
        logic [AW-1:0] ea;
        int s, d, q0, ld0, re0, dn0, bad;
        bit ok;
        for (int i = 0; i < 8; i++) snap[i] = rf[i];
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + snap[i];
        lat = L;
        q0  = wr_q.size();
        ld0 = ld_busy_cnt;
        re0 = re_cnt;
        dn0 = done_cnt;
        start_op(1'b1, both, base, s);
        if (cpu_wr) begin
            CPU_LD_REG = 1'b1;
            CPU_DR     = 3'd3;
            CPU_BUS    = 16'hBEEF;
        end
        wait_done(noise, d, ok);
        if (ok) begin
            check("save_latency", d - s, N * (L + 1) + 1);
            check("save_csum", 32'(Checksum), CSUM_ON ? 32'(sum) : 32'd0);
        end
        @(negedge Clk);
        check("save_idle_busy", 32'(Busy), 32'd0);
        check("save_csum_hold", 32'(Checksum), CSUM_ON ? 32'(sum) : 32'd0);
        check("save_nwrites", wr_q.size() - q0, N);
        for (int i = 0; i < N; i++) begin
            if (q0 + i < wr_q.size()) begin
                ea = base + AW'(i);
                check("save_addr", 32'(wr_q[q0 + i].a), 32'(ea));
                check("save_data", 32'(wr_q[q0 + i].d), 32'(snap[i]));
            end
        end
        bad = 0;
        for (int i = 0; i < 8; i++) if (rf[i] !== snap[i]) bad++;
        check("save_rf_kept", bad, 0);
        check("save_no_rf_ld", ld_busy_cnt - ld0, 0);
        check("save_no_re", re_cnt - re0, 0);
        check("save_done_cnt", done_cnt - dn0, 1);
    endtask

    task automatic run_restore(input logic [AW-1:0] base, input int L, input bit noise,
                               input bit directed);
        logic [DW-1:0] expv [0:7];
        logic [DW-1:0] sum;
        logic [AW-1:0] ea;
        int s, d, q0, ld0, dn0;
        bit ok;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            expv[i] = directed ? 16'hA0A0 + 16'(i) : 16'($urandom);
            ea      = base + AW'(i);
            mem[ea] = expv[i];
            sum     = sum + expv[i];
        end
        lat = L;
        q0  = wr_q.size();
        ld0 = ld_busy_cnt;
        dn0 = done_cnt;
        start_op(1'b0, 1'b1, base, s);
        wait_done(noise, d, ok);
        if (ok) begin
            check("rest_latency", d - s, N * (L + 2) + 1);
            check("rest_csum", 32'(Checksum), CSUM_ON ? 32'(sum) : 32'd0);
        end
        @(negedge Clk);
        check("rest_idle_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < N; i++) check("rest_reg", 32'(rf[i]), 32'(expv[i]));
        check("rest_ld_pulses", ld_busy_cnt - ld0, N);
        check("rest_no_writes", wr_q.size() - q0, 0);
        check("rest_done_cnt", done_cnt - dn0, 1);
    endtask

    initial begin
        int s, dn0, q0, op, L;
        logic [AW-1:0] base;
        Reset = 1'b1; Start_Save = 1'b0; Start_Restore = 1'b0; Base_Addr = '0;
        CPU_SR1 = '0; CPU_DR = '0; CPU_LD_REG = 1'b0; CPU_BUS = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_we", 32'(MEM_WE), 32'd0);
        check("rst_re", 32'(MEM_RE), 32'd0);
        check("rst_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_wdata", 32'(MEM_WDATA), 32'd0);
        check("rst_csum", 32'(Checksum), 32'd0);
        Reset = 1'b0;

        // Idle passthrough.
        CPU_SR1 = 3'd2; CPU_DR = 3'd5; CPU_BUS = 16'h1234; CPU_LD_REG = 1'b1;
        #1;
        check("pt_sr1", 32'(RF_SR1), 32'd2);
        check("pt_dr", 32'(RF_DR), 32'd5);
        check("pt_bus", 32'(RF_BUS), 32'h1234);
        check("pt_ld", 32'(RF_LD_REG), 32'd1);
        @(negedge Clk);
        CPU_LD_REG = 1'b0;
        CPU_SR1    = 3'd6;
        #1;
        check("pt_r5", 32'(rf[5]), 32'h1234);
        check("pt_sr1_follow", 32'(RF_SR1), 32'd6);

        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            CPU_DR = 3'(i); CPU_BUS = 16'h1000 + 16'(i); CPU_LD_REG = 1'b1;
        end
        @(negedge Clk);
        CPU_LD_REG = 1'b0;

        run_save(16'h3000, 0, 1'b0, 1'b0, 1'b0);
        run_restore(16'h4000, 2, 1'b0, 1'b1);
        run_save(16'hFFFE, 0, 1'b0, 1'b0, 1'b0);
        run_save(16'h2000, 0, 1'b0, 1'b1, 1'b1);

        // Reset during the third SAVE cycle.
        lat = 0;
        dn0 = done_cnt;
        q0  = wr_q.size();
        start_op(1'b1, 1'b0, 16'h5000, s);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_we", 32'(MEM_WE), 32'd0);
        check("mid_rst_addr", 32'(MEM_ADDR), 32'd0);
        check("mid_rst_csum", 32'(Checksum), 32'd0);
        repeat (20) @(negedge Clk);
        check("mid_rst_no_done", done_cnt - dn0, 0);
        check("mid_rst_writes", wr_q.size() - q0, 3);
        run_save(16'h5000, 1, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            op   = $urandom_range(0, 2);
            L    = $urandom_range(0, 3);
            base = (it % 4 == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            if (op == 0)      run_save(base, L, 1'b1, 1'b0, 1'b0);
            else if (op == 1) run_restore(base, L, 1'b1, 1'b0);
            else              run_save(base, L, 1'b1, 1'b1, 1'b0);
        end

        check("we_re_overlap", ov_err, 0);
        check("ld_pulse_width", pulse_err, 0);
        check("addr_stable", stab_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_ctx_sequencer.md
Name: reg_ctx_sequencer

Overview:
- Context save/restore sequencer for the 8x16 LC-3 register file.
- On request, it takes ownership of the register file's SR1 read port and its write port (DR/LD_REG/BUS).
- Save: streams R0..R(NUM_REGS-1) to memory at consecutive addresses. Restore: streams them back in the same order.
- When idle, the CPU datapath's register-file controls pass through unchanged. Used for interrupt entry/exit and debug dumps.

Parameters:
- NUM_REGS, 8, number of registers transferred (1..8), always starting at R0.
- DATA_W, 16, register/memory data width.
- ADDR_W, 16, memory address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start_Save  in  1  request a save; sampled only in IDLE.
- Start_Restore  in  1  request a restore; sampled only in IDLE.
- Base_Addr  in  ADDR_W  first memory address; captured on start.
- Busy  out  1  sequencer owns the register file (state != IDLE).
- Done  out  1  one-cycle pulse when a transfer completes.
- Checksum  out  DATA_W  see Optional Feature.
- CPU_SR1  in  3  datapath SR1 select.
- CPU_DR  in  3  datapath destination select.
- CPU_LD_REG  in  1  datapath write enable.
- CPU_BUS  in  DATA_W  datapath write data.
- RF_SR1  out  3  to register file SR1.
- RF_DR  out  3  to register file DR.
- RF_LD_REG  out  1  to register file LD_REG.
- RF_BUS  out  DATA_W  to register file BUS.
- RF_SR1OUT  in  DATA_W  register file SR1 read data (combinational).
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_WE  out  1  write request.
- MEM_RE  out  1  read request.
- MEM_RDATA  in  DATA_W  read data, valid when MEM_READY=1.
- MEM_READY  in  1  memory completes the current request this cycle.

Behaviour:
- States: IDLE, SAVE, RESTORE_RD, RESTORE_WR, DONE. Index register idx (3 bits); address register addr = Base_Addr + idx, modulo 2^ADDR_W (wraps FFFF->0000).
- Reset, synchronous and also mid-transfer: state=IDLE, idx=0, Busy=0, Done=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0, Checksum=0. No further memory requests are issued.
- IDLE:
  - RF_* outputs equal the corresponding CPU_* inputs combinationally.
  - Start_Save=1 -> SAVE. Otherwise Start_Restore=1 -> RESTORE_RD. Both high: save wins and the restore is dropped.
  - On start: capture Base_Addr, set idx=0.
- SAVE:
  - RF_SR1=idx, MEM_WE=1, MEM_ADDR=addr, MEM_WDATA=RF_SR1OUT. Request held stable until MEM_READY=1.
  - On the MEM_READY edge: if idx=NUM_REGS-1 -> DONE, else idx+1 and stay in SAVE.
  - With MEM_READY tied high, one register per cycle.
- RESTORE_RD:
  - MEM_RE=1, MEM_ADDR=addr.
  - On MEM_READY: capture MEM_RDATA into a hold register, go to RESTORE_WR.
- RESTORE_WR:
  - RF_DR=idx, RF_BUS=hold register, RF_LD_REG=1 for exactly one cycle. MEM_RE=0.
  - Then: if idx=NUM_REGS-1 -> DONE, else idx+1 -> RESTORE_RD.
- DONE: Done=1 for one cycle, then IDLE. Busy is still 1 in DONE.
- While Busy:
  - CPU_LD_REG is ignored: no CPU write reaches the register file, and it is not queued.
  - RF_SR1 is driven by the sequencer in SAVE and by CPU_SR1 in all other busy states.
  - RF_LD_REG=0 except in RESTORE_WR.
- Start inputs asserted while Busy are ignored, not queued.
- MEM_WE and MEM_RE are never high simultaneously. Both are 0 outside SAVE/RESTORE_RD.
- Latency with MEM_READY tied high, start in cycle 0:
  - Save, NUM_REGS=8: SAVE in cycles 1..8, Done in cycle 9.
  - Restore, NUM_REGS=8: 16 cycles RD/WR, Done in cycle 17.

Optional Feature:
- Macro: REG_CTX_CHECKSUM_EN.
- Defined:
  - Checksum clears to 0 on start.
  - It accumulates every transferred word (saved RF_SR1OUT, or restored MEM_RDATA) modulo 2^DATA_W, updated on each MEM_READY handshake.
  - Value is final and stable from the DONE cycle until the next start.
- Undefined: Checksum is constant 0 and no adder is built.

Test Plan:
- Preload R0..R7=0x1000..0x1007, MEM_READY=1, Start_Save, Base_Addr=0x3000 -> writes 0x3000..0x3007 = 0x1000..0x1007 in cycles 1..8; Done in cycle 9. With REG_CTX_CHECKSUM_EN, Checksum=0x801C.
- Memory 0x4000..0x4007=0xA0A0+i, MEM_READY delayed 2 cycles per access, Start_Restore, Base_Addr=0x4000 -> R0..R7=0xA0A0..0xA0A7; exactly 8 single-cycle RF_LD_REG pulses; MEM_ADDR stable while waiting.
- Base_Addr=0xFFFE save -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005.
- Start_Save and Start_Restore high together -> save performed, MEM_RE never asserted. CPU_LD_REG=1, CPU_DR=3, CPU_BUS=0xBEEF during save -> R3 unchanged.
- Reset asserted in the third SAVE cycle -> next cycle Busy=0, MEM_WE=0, Done never pulses; later start works normally.
- Idle passthrough: CPU_DR=5, CPU_BUS=0x1234, CPU_LD_REG=1 -> R5=0x1234 next cycle; RF_SR1 follows CPU_SR1.
